// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the debug run-control sequencer: host opcodes,
// controller states and stop reasons.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_RUN     = 3'd1,
    OP_HALT    = 3'd2,
    OP_STEP    = 3'd3,
    OP_SET_BP0 = 3'd4,
    OP_SET_BP1 = 3'd5,
    OP_CLR_CNT = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_STOP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RSN_HOST      = 2'd0,
    RSN_CORE_HALT = 2'd1,
    RSN_BP        = 2'd2,
    RSN_STEP_DONE = 2'd3
  } reason_e;

  function automatic logic is_active(state_e s);
    return (s == S_RUN) || (s == S_STEP);
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Host command channel of the run controller: valid/ready handshake with
// an opcode and a CNT_W-wide argument.
interface run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/run_controller_bp_compare.sv
// PC breakpoint table: NUM_BP address/enable pairs with a one-hot write port
// and a combinational match against the PC the core issues next.
module bp_compare #(
  parameter int ADDR_W = 16,
  parameter int NUM_BP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_BP-1:0] wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] pc,
  output logic              match
);

  logic [ADDR_W-1:0] bp_addr [NUM_BP];
  logic [NUM_BP-1:0] bp_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: a register table this small has an architectural reset value
      // (disabled, address 0), so it is cleared here, unlike a RAM array.
      for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
      bp_en <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr[i]) begin
          bp_addr[i] <= wr_addr;
          bp_en[i]   <= wr_enable;
        end
      end
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (bp_addr[i] == pc)) match = 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Debug run-control sequencer: turns host run/halt/step commands into a
// per-cycle core clock enable, reports why the core stopped and how long it ran.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32,
  parameter int NUM_BP = 2
) (
  input  logic              clk,
  input  logic              reset,
  run_ctrl_if.slave         cmd,
  input  logic [ADDR_W-1:0] core_pc,
  input  logic              core_halt,
  output logic              clk_en,
  output logic              running,
  output logic              stop_valid,
  output logic [1:0]        stop_reason,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e            state, state_nx;
  reason_e           rsn_q, rsn_nx;
  logic [CNT_W-1:0]  step_cnt;
  logic              skip;
  logic              accept;
  op_e               op;
  logic [NUM_BP-1:0] bp_wr;
  logic              bp_hit;

  assign op            = op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = (state != S_STOP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign running       = is_active(state);
  assign stop_valid    = (state == S_STOP);
  assign stop_reason   = rsn_q;

  // Only the two SET_BPx opcodes exist, so entries beyond 1 are never written.
  always_comb begin
    bp_wr = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_wr[i] = accept && (i < 2) && (cmd.cmd_op == 3'(int'(OP_SET_BP0) + i));
    end
  end

  bp_compare #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP)
  ) u_bp (
    .clk       (clk),
    .reset     (reset),
    .wr        (bp_wr),
    .wr_addr   (cmd.cmd_arg[ADDR_W-1:0]),
    .wr_enable (cmd.cmd_arg[CNT_W-1]),
    .pc        (core_pc),
    .match     (bp_hit)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned and infers a latch.
    state_nx = state;
    rsn_nx   = rsn_q;
    clk_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && op == OP_RUN)       state_nx = S_RUN;
        else if (accept && op == OP_STEP) state_nx = S_STEP;
      end
      S_RUN, S_STEP: begin
        if (accept && op == OP_HALT) begin
          state_nx = S_STOP;
          rsn_nx   = RSN_HOST;
        end else if (core_halt) begin
          state_nx = S_STOP;
          rsn_nx   = RSN_CORE_HALT;
        end else if (bp_hit && !skip) begin
          state_nx = S_STOP;
          rsn_nx   = RSN_BP;
        end else begin
          clk_en = 1'b1;
          if (state == S_STEP && step_cnt == ONE) begin
            state_nx = S_STOP;
            rsn_nx   = RSN_STEP_DONE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state       <= S_IDLE;
      rsn_q       <= RSN_HOST;
      step_cnt    <= '0;
      skip        <= 1'b0;
      cycle_count <= '0;
    end else begin
      state <= state_nx;
      rsn_q <= rsn_nx;

      if (state == S_IDLE && accept && op == OP_STEP)
        step_cnt <= (cmd.cmd_arg == '0) ? ONE : cmd.cmd_arg;
      else if (state == S_STEP && clk_en)
        step_cnt <= step_cnt - ONE;

      // Resuming from a breakpoint must execute the instruction sitting on it.
      if (state == S_IDLE && accept && (op == OP_RUN || op == OP_STEP))
        skip <= 1'b1;
      else if (running)
        skip <= 1'b0;

      if (accept && op == OP_CLR_CNT)
        cycle_count <= '0;
      else if (clk_en && cycle_count != '1)
        cycle_count <= cycle_count + ONE;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: vector table plus hand-written
// breakpoint, priority, saturation and reset sequences, stops scored via a queue.
module tb_run_controller;
  import run_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] core_pc;
  logic        core_halt;
  logic        clk_en, running, stop_valid;
  logic [1:0]  stop_reason;
  logic [31:0] cycle_count;

  logic [3:0]  pc8;
  logic        halt8;
  logic        clk_en8, running8, stop_valid8;
  logic [1:0]  reason8;
  logic [7:0]  cnt8;

  run_ctrl_if #(.CNT_W(32)) h ();
  run_ctrl_if #(.CNT_W(8))  h8 ();

  run_controller #(.ADDR_W(16), .CNT_W(32), .NUM_BP(2)) dut (
    .clk (clk), .reset (reset), .cmd (h), .core_pc (core_pc), .core_halt (core_halt),
    .clk_en (clk_en), .running (running), .stop_valid (stop_valid),
    .stop_reason (stop_reason), .cycle_count (cycle_count)
  );

  run_controller #(.ADDR_W(4), .CNT_W(8), .NUM_BP(2)) dut8 (
    .clk (clk), .reset (reset), .cmd (h8), .core_pc (pc8), .core_halt (halt8),
    .clk_en (clk_en8), .running (running8), .stop_valid (stop_valid8),
    .stop_reason (reason8), .cycle_count (cnt8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  typedef struct {
    reason_e     rsn;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    op_e         op;
    logic [31:0] arg;
    int          halt_after;
    reason_e     rsn;
    int          pulses;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input op_e op, input logic [31:0] arg);
    h.cmd_valid = 1'b1;
    h.cmd_op    = op;
    h.cmd_arg   = arg;
    next_cyc();
    h.cmd_valid = 1'b0;
    h.cmd_op    = OP_NOP;
    h.cmd_arg   = '0;
  endtask

  task automatic send8(input op_e op);
    h8.cmd_valid = 1'b1;
    h8.cmd_op    = op;
    h8.cmd_arg   = '0;
    next_cyc();
    h8.cmd_valid = 1'b0;
    h8.cmd_op    = OP_NOP;
  endtask

  task automatic wait_stop(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = stop_valid;
    end
    if (!seen) check1({name, "_stop_timeout"}, stop_valid, 1'b1);
    next_cyc();
  endtask

  // Stop monitor: every stop_valid pulse must match the oldest expected stop.
  always @(negedge clk) begin
    if (clk_en) pulses++;
    if (stop_valid) begin
      if (sb.size() == 0) begin
        check1("unexpected_stop", stop_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("stop_reason", {30'b0, stop_reason}, {30'b0, e.rsn});
        check("stop_cycle_count", cycle_count, e.cnt);
      end
    end
  end

  initial begin
    vecs[0] = '{OP_STEP, 32'd3,  0, RSN_STEP_DONE, 3};
    vecs[1] = '{OP_STEP, 32'd0,  0, RSN_STEP_DONE, 1};
    vecs[2] = '{OP_STEP, 32'd1,  0, RSN_STEP_DONE, 1};
    vecs[3] = '{OP_STEP, 32'd7,  0, RSN_STEP_DONE, 7};
    vecs[4] = '{OP_RUN,  32'd0,  4, RSN_HOST,      4};
    vecs[5] = '{OP_STEP, 32'd10, 2, RSN_HOST,      2};

    reset = 1'b0;
    h.cmd_valid = 1'b0;  h.cmd_op = OP_NOP;  h.cmd_arg = '0;
    h8.cmd_valid = 1'b0; h8.cmd_op = OP_NOP; h8.cmd_arg = '0;
    core_pc = 16'h0100; core_halt = 1'b0; pc8 = 4'h0; halt8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    @(negedge clk);
    check1("rst_clk_en", clk_en, 1'b0);
    check1("rst_running", running, 1'b0);
    check1("rst_stop_valid", stop_valid, 1'b0);
    check1("rst_cmd_ready", h.cmd_ready, 1'b1);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_stop_reason", {30'b0, stop_reason}, 32'd0);

    // STEP 3 cycle by cycle: enables at t+1..t+3, stop pulse at t+4.
    sb.push_back('{RSN_STEP_DONE, 32'd3});
    send(OP_STEP, 32'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("step3_clk_en", clk_en, i < 3);
      check1("step3_stop_valid", stop_valid, i == 3);
      check1("step3_cmd_ready", h.cmd_ready, i != 3);
      next_cyc();
    end
    @(negedge clk);
    check1("step3_idle_running", running, 1'b0);
    check1("step3_idle_stop_valid", stop_valid, 1'b0);
    check("step3_reason_held", {30'b0, stop_reason}, {30'b0, RSN_STEP_DONE});
    check("step3_count", cycle_count, 32'd3);
    next_cyc();

    for (int i = 0; i < 6; i++) begin
      send(OP_CLR_CNT, '0);
      pulses = 0;
      sb.push_back('{vecs[i].rsn, vecs[i].pulses});
      send(vecs[i].op, vecs[i].arg);
      if (vecs[i].halt_after > 0) begin
        repeat (vecs[i].halt_after) next_cyc();
        send(OP_HALT, '0);
      end
      wait_stop("vec");
      check("vec_pulses", pulses, vecs[i].pulses);
    end

    // Breakpoint hit, then resume from the breakpoint address.
    send(OP_CLR_CNT, '0);
    core_pc = 16'h000C;
    send(OP_SET_BP0, 32'h8000_0010);
    sb.push_back('{RSN_BP, 32'd2});
    send(OP_RUN, '0);
    @(negedge clk); check1("bp_pc_0c", clk_en, 1'b1);
    next_cyc(); core_pc = 16'h000E;
    @(negedge clk); check1("bp_pc_0e", clk_en, 1'b1);
    next_cyc(); core_pc = 16'h0010;
    @(negedge clk); check1("bp_pc_10_hit", clk_en, 1'b0);
    wait_stop("bp0");
    sb.push_back('{RSN_HOST, 32'd3});
    send(OP_RUN, '0);
    @(negedge clk);
    check1("bp_resume_clk_en", clk_en, 1'b1);
    check1("bp_resume_running", running, 1'b1);
    next_cyc(); core_pc = 16'h0012;
    send(OP_HALT, '0);
    wait_stop("bp_resume");

    // Second breakpoint slot, with slot 0 disabled.
    send(OP_SET_BP0, 32'h0000_0010);
    send(OP_SET_BP1, 32'h8000_0014);
    send(OP_CLR_CNT, '0);
    sb.push_back('{RSN_BP, 32'd1});
    send(OP_RUN, '0);
    next_cyc(); core_pc = 16'h0014;
    wait_stop("bp1");
    send(OP_SET_BP1, '0);
    core_pc = 16'h0100;

    // Host HALT outranks core_halt in the same cycle.
    send(OP_CLR_CNT, '0);
    sb.push_back('{RSN_HOST, 32'd5});
    send(OP_RUN, '0);
    repeat (5) next_cyc();
    core_halt = 1'b1;
    send(OP_HALT, '0);
    core_halt = 1'b0;
    wait_stop("prio_host");

    send(OP_CLR_CNT, '0);
    sb.push_back('{RSN_CORE_HALT, 32'd5});
    send(OP_RUN, '0);
    repeat (5) next_cyc();
    core_halt = 1'b1;
    wait_stop("prio_core");
    core_halt = 1'b0;

    // core_halt is not masked by the first-cycle skip.
    send(OP_CLR_CNT, '0);
    sb.push_back('{RSN_CORE_HALT, 32'd0});
    core_halt = 1'b1;
    send(OP_RUN, '0);
    wait_stop("core_halt_first");
    core_halt = 1'b0;

    // 8-bit counter saturates, then clears mid-run and counts again.
    send8(OP_RUN);
    repeat (300) next_cyc();
    @(negedge clk);
    check("sat_count", {24'b0, cnt8}, 32'hFF);
    check1("sat_running", running8, 1'b1);
    send8(OP_CLR_CNT);
    @(negedge clk); check("clr_count0", {24'b0, cnt8}, 32'd0);
    next_cyc();
    @(negedge clk); check("clr_count1", {24'b0, cnt8}, 32'd1);
    send8(OP_HALT);
    @(negedge clk);
    check1("sat_stop_valid", stop_valid8, 1'b1);
    check("sat_stop_reason", {30'b0, reason8}, {30'b0, RSN_HOST});
    check("sat_stop_count", {24'b0, cnt8}, 32'd1);
    next_cyc();

    // Reset in the middle of STEP 10 aborts silently and clears breakpoints.
    send(OP_SET_BP0, 32'h8000_0200);
    send(OP_CLR_CNT, '0);
    send(OP_STEP, 32'd10);
    repeat (4) next_cyc();
    reset = 1'b0;
    next_cyc();
    reset = 1'b1;
    @(negedge clk);
    check1("mrst_running", running, 1'b0);
    check1("mrst_clk_en", clk_en, 1'b0);
    check1("mrst_stop_valid", stop_valid, 1'b0);
    check1("mrst_cmd_ready", h.cmd_ready, 1'b1);
    check("mrst_count", cycle_count, 32'd0);
    check("mrst_reason", {30'b0, stop_reason}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      @(negedge clk);
      check1("mrst_no_stop", stop_valid, 1'b0);
    end
    next_cyc();
    core_pc = 16'h0200;
    sb.push_back('{RSN_HOST, 32'd3});
    send(OP_RUN, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("mrst_bp_disabled", clk_en, 1'b1);
      next_cyc();
    end
    send(OP_HALT, '0);
    wait_stop("mrst_run");

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Debug run-control sequencer for the processor core.
- Accepts host commands (run, halt, step N, set breakpoint, clear counter) and drives a per-cycle clock-enable to the core; the core advances one instruction per cycle while clk_en=1.
- Stops on host halt, core HALT instruction, PC breakpoint or step-count exhaustion.
- Reports the stop reason and an executed-cycle counter.

Parameters:
- ADDR_W, 16, width of core PC and breakpoint addresses.
- CNT_W, 32, width of cmd_arg, step counter and cycle counter (CNT_W > ADDR_W).
- NUM_BP, 2, number of PC breakpoints (op encoding supports 2).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset: asserted when 0, sampled on the rising edge of clk.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP0, 5 SET_BP1, 6 CLR_CNT, 7 reserved.
- cmd_arg  in  CNT_W  STEP: count. SET_BPx: [ADDR_W-1:0] address, [CNT_W-1] enable.
- core_pc  in  ADDR_W  PC of the instruction the core issues next.
- core_halt  in  1  level; the instruction at core_pc is HALT.
- clk_en  out  1  core advance enable (combinational from state and inputs).
- running  out  1  state is RUN or STEP.
- stop_valid  out  1  one-cycle pulse in STOP.
- stop_reason  out  2  0 HOST, 1 CORE_HALT, 2 BREAKPOINT, 3 STEP_DONE; held until the next stop.
- cycle_count  out  CNT_W  number of cycles with clk_en=1.

Behaviour:
- Reset (reset=0 at an edge):
  - State to IDLE.
  - Breakpoints disabled and addresses 0.
  - Step counter, cycle_count and stop_reason to 0; skip flag cleared.
  - Outputs: clk_en=0, running=0, stop_valid=0. cmd_ready=1 from the first cycle after reset.
  - Reset mid-RUN/STEP aborts with no stop_valid.
- States and cmd_ready:
  - IDLE, RUN, STEP: cmd_ready=1.
  - STOP: cmd_ready=0. STOP lasts exactly one cycle, asserts stop_valid and latches stop_reason, then returns to IDLE.
- IDLE:
  - RUN goes to RUN next cycle.
  - STEP goes to STEP next cycle; the step counter loads cmd_arg, with 0 treated as 1.
  - HALT, NOP and reserved have no effect.
  - Latency: command accepted at cycle t gives clk_en=1 earliest at t+1.
- Commands in RUN/STEP:
  - HALT stops with reason HOST; clk_en=0 in the accept cycle.
  - RUN and STEP are accepted and ignored.
- Ops valid in any state where accepted:
  - SET_BPx and CLR_CNT apply in any non-STOP state.
  - CLR_CNT zeroes cycle_count; clear beats increment in the same cycle.
- Skip flag:
  - Set on entry to RUN/STEP.
  - Suppresses breakpoint matches for the first active cycle only, so resuming from a breakpoint address executes that instruction.
  - Cleared after the first RUN/STEP cycle.
- Per active cycle (RUN or STEP), stop conditions in priority order:
  - Host HALT accepted → HOST.
  - core_halt=1 → CORE_HALT (not suppressed by skip).
  - Enabled breakpoint with address == core_pc and skip=0 → BREAKPOINT.
  - In each of the above cases: clk_en=0 and next state STOP.
  - Otherwise clk_en=1.
- STEP counting:
  - Each cycle with clk_en=1 decrements the counter.
  - If the counter was 1, next state is STOP with reason STEP_DONE. STEP N gives exactly N clk_en pulses unless stopped earlier.
- cycle_count increments on clk_en=1 and saturates at all-ones; no wrap.
- clk_en is 0 in IDLE and STOP regardless of inputs.

Decomposition:
- Shared package run_ctrl_pkg:
  - op codes (OP_NOP..OP_CLR_CNT)
  - state enum (S_IDLE, S_RUN, S_STEP, S_STOP)
  - reason codes (RSN_HOST, RSN_CORE_HALT, RSN_BP, RSN_STEP_DONE)
- One sub-module bp_compare: NUM_BP address/enable registers, write port, and a match output against core_pc.
- FSM and counters stay in run_controller.

Test Plan:
- Release reset, STEP arg=3 at cycle t → clk_en high cycles t+1..t+3, stop_valid at t+4, stop_reason=3, cycle_count=3.
- STEP arg=0 → exactly one clk_en pulse, reason STEP_DONE.
- SET_BP0 addr=0x0010 en=1, RUN, core_pc counts 0x000C,0x000E,0x0010 → clk_en=0 at PC 0x0010, reason=2. RUN again with PC still 0x0010 → first cycle clk_en=1, no immediate stop.
- RUN, assert core_halt after 5 active cycles with HALT issued the same cycle → reason HOST (priority), cycle_count=5. Repeat with core_halt alone → reason CORE_HALT.
- cycle_count preset near all-ones via long RUN (CNT_W=8 variant) → saturates at 0xFF. CLR_CNT during RUN → 0 next cycle, counting resumes.
- Reset=0 mid-STEP arg=10 after 4 pulses → next cycle IDLE, clk_en=0, no stop_valid, cycle_count=0, breakpoints disabled.
